// File: rtl/bht_update_gen.sv
// bht_update_gen: in-order FIFO of fetch-side branch predictions. Each entry is matched
// against the next resolved branch and turned into a registered predictor update.
// Ports:
//   clk_i, rst_ni                       clock; synchronous active-low reset
//   flush_i                             drops every in-flight entry
//   debug_mode_i                        suppresses upd_valid_o
//   push_valid_i/push_ready_o           accept {push_pc_i, push_taken_i, push_index_i}
//   resolve_valid_i                     oldest branch resolved: {resolve_pc_i, resolve_taken_i}
//   upd_valid_o, upd_pc_o, upd_taken_o, upd_index_o, mispredict_o   registered update, one cycle
//   order_err_o                         sticky ordering error
//   count_o                             occupancy
module bht_update_gen #(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [VLEN-1:0]            push_pc_i,
  input  logic                       push_taken_i,
  input  logic [IDX_W-1:0]           push_index_i,
  input  logic                       resolve_valid_i,
  input  logic [VLEN-1:0]            resolve_pc_i,
  input  logic                       resolve_taken_i,
  output logic                       upd_valid_o,
  output logic [VLEN-1:0]            upd_pc_o,
  output logic                       upd_taken_o,
  output logic [IDX_W-1:0]           upd_index_o,
  output logic                       mispredict_o,
  output logic                       order_err_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [VLEN-1:0]  pc_mem  [DEPTH];
  logic             tk_mem  [DEPTH];
  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             upd_valid_q, upd_taken_q, mispredict_q, order_err_q;
  logic [VLEN-1:0]  upd_pc_q;
  logic [IDX_W-1:0] upd_index_q;
  logic             do_push, do_pop, hit, err_set;
  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign push_ready_o = count_q < CW'(DEPTH);
  assign do_push      = push_valid_i && push_ready_o && !flush_i;
  assign do_pop       = resolve_valid_i && (count_q != '0) && !flush_i;
  assign hit          = do_pop && (resolve_pc_i == pc_mem[rd_q]);
  // A resolve with nothing queued, or whose PC is not the head, means the streams diverged.
  assign err_set      = resolve_valid_i && !flush_i && ((count_q == '0) || !hit);
  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_d    = flush_i ? '0 : wr_q + PW'(do_push);
    rd_d    = flush_i ? '0 : rd_q + PW'(do_pop);
    count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_index_q  <= '0;
      mispredict_q <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      upd_valid_q  <= hit && !debug_mode_i;
      mispredict_q <= hit && (resolve_taken_i != tk_mem[rd_q]);
      if (hit) begin
        upd_pc_q    <= pc_mem[rd_q];
        upd_taken_q <= resolve_taken_i;
        upd_index_q <= idx_mem[rd_q];
      end
      if (err_set) order_err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_mem[wr_q]  <= push_pc_i;
      tk_mem[wr_q]  <= push_taken_i;
      idx_mem[wr_q] <= push_index_i;
    end
  end
  assign upd_valid_o  = upd_valid_q;
  assign upd_pc_o     = upd_pc_q;
  assign upd_taken_o  = upd_taken_q;
  assign upd_index_o  = upd_index_q;
  assign mispredict_o = mispredict_q;
  assign order_err_o  = order_err_q;
  assign count_o      = count_q;
endmodule

// File: tb/tb_bht_update_gen.sv
// tb_bht_update_gen: scoreboard bench for bht_update_gen against a queue-based reference model.
module tb_bht_update_gen;
  localparam int VLEN = 64, IDX_W = 10, DEPTH = 8, CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0, flush = 0, dbg = 0, push_v = 0, push_tk = 0, res_v = 0, res_tk = 0;
  logic [VLEN-1:0] push_pc = '0, res_pc = '0;
  logic [IDX_W-1:0] push_idx = '0;
  logic push_rdy, upd_v, upd_tk, mp, oerr;
  logic [VLEN-1:0] upd_pc;
  logic [IDX_W-1:0] upd_idx;
  logic [CW-1:0] cnt;
  bht_update_gen #(.VLEN(VLEN), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(dbg),
    .push_valid_i(push_v), .push_ready_o(push_rdy), .push_pc_i(push_pc),
    .push_taken_i(push_tk), .push_index_i(push_idx),
    .resolve_valid_i(res_v), .resolve_pc_i(res_pc), .resolve_taken_i(res_tk),
    .upd_valid_o(upd_v), .upd_pc_o(upd_pc), .upd_taken_o(upd_tk), .upd_index_o(upd_idx),
    .mispredict_o(mp), .order_err_o(oerr), .count_o(cnt)
  );
  always #5 clk = ~clk;
  typedef struct { logic [VLEN-1:0] pc; bit tk; logic [IDX_W-1:0] idx; } ent_t;
  typedef struct { int cyc; bit v; bit mp; bit tk; logic [VLEN-1:0] pc; logic [IDX_W-1:0] idx; } exp_t;
  ent_t mq[$];
  exp_t eq[$];
  bit merr = 0, armed = 0;
  int cyc = 0, total = 0, bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask
  always @(negedge clk) if (armed) begin
    exp_t e;
    if (eq.size() > 0 && eq[0].cyc == cyc) begin
      e = eq.pop_front();
      chk("upd_valid", 64'(upd_v), 64'(e.v));
      chk("mispredict", 64'(mp), 64'(e.mp));
      chk("upd_taken", 64'(upd_tk), 64'(e.tk));
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_index", 64'(upd_idx), 64'(e.idx));
    end else begin
      chk("idle_upd_valid", 64'(upd_v), 64'(0));
      chk("idle_mispredict", 64'(mp), 64'(0));
    end
    chk("count", 64'(cnt), 64'(mq.size()));
    chk("push_ready", 64'(push_rdy), 64'(mq.size() < DEPTH));
    chk("order_err", 64'(oerr), 64'(merr));
  end
  // Reference: apply the inputs present at the coming edge to the model queue.
  task automatic model();
    int n;
    ent_t h;
    n = mq.size();
    if (!rst_n) begin
      mq.delete();
      merr = 0;
      eq.push_back('{cyc + 1, 0, 0, 0, '0, '0});
    end else if (!flush) begin
      if (res_v && n == 0) merr = 1;
      if (res_v && n > 0) begin
        h = mq.pop_front();
        if (h.pc == res_pc) eq.push_back('{cyc + 1, !dbg, res_tk != h.tk, res_tk, h.pc, h.idx});
        else merr = 1;
      end
      if (push_v && n < DEPTH) mq.push_back('{push_pc, push_tk, push_idx});
    end else mq.delete();
  endtask
  task automatic step();
    @(negedge clk);
    #1;
    model();
    armed = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    rst_n = 1; flush = 0; dbg = 0; push_v = 0; res_v = 0;
  endtask
  task automatic set_push(input logic [VLEN-1:0] pc, input bit tk, input logic [IDX_W-1:0] idx);
    push_v = 1; push_pc = pc; push_tk = tk; push_idx = idx;
  endtask
  task automatic set_res(input logic [VLEN-1:0] pc, input bit tk);
    res_v = 1; res_pc = pc; res_tk = tk;
  endtask
  task automatic push1(input logic [VLEN-1:0] pc, input bit tk, input logic [IDX_W-1:0] idx);
    set_push(pc, tk, idx); step(); clr();
  endtask
  task automatic res_head(input bit tk);
    set_res(mq.size() > 0 ? mq[0].pc : 64'h0, tk); step(); clr();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; step(); step(); clr();
    push1(64'h1000, 1, 10'd5);
    set_res(64'h1000, 0); step(); clr();
    step();
    for (int i = 0; i < DEPTH; i++) push1(64'h100 + 64'(i * 4), i[0], IDX_W'(i));
    step();
    set_push(64'hdead, 1, 10'd99); set_res(mq[0].pc, 1); step(); clr();
    while (mq.size() > 0) res_head(1'($urandom));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) push1(64'h4000 + 64'(r * 256 + i * 4), 1'($urandom), IDX_W'(r * 16 + i));
      for (int i = 0; i < DEPTH; i++) res_head(1'($urandom));
    end
    push1(64'h2000, 0, 10'd7);
    set_res(64'h2004, 0); step(); clr();
    flush = 1; step(); clr();
    step();
    for (int i = 0; i < 3; i++) push1(64'h3000 + 64'(i * 4), 1, IDX_W'(i + 20));
    flush = 1; set_res(mq[0].pc, 0); step(); clr();
    step();
    push1(64'h5000, 1, 10'd33);
    dbg = 1; res_head(0);
    for (int i = 0; i < 4; i++) push1(64'h6000 + 64'(i * 4), 0, IDX_W'(i));
    rst_n = 0; step(); clr();
    set_res(64'h6000, 0); step(); clr();
    rst_n = 0; step(); clr();
    for (int i = 0; i < 3000; i++) begin
      clr();
      if ($urandom_range(0, 1)) set_push(64'h8000 + 64'($urandom_range(0, 63) * 4), 1'($urandom), IDX_W'($urandom));
      if ($urandom_range(0, 2) == 0)
        set_res((mq.size() > 0 && $urandom_range(0, 15) != 0) ? mq[0].pc : 64'h8000 + 64'($urandom_range(0, 63) * 4), 1'($urandom));
      flush = ($urandom_range(0, 39) == 0);
      dbg = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    clr();
    for (int i = 0; i < 3; i++) step();
    chk("leftover_expected", 64'(eq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bht_update_gen.md
BHT_UPDATE_GEN -- requirements
Module: bht_update_gen

Interface
REQ-001 SHALL have parameter VLEN, default 64, meaning PC width (bound to CVA6Cfg.VLEN).
REQ-002 SHALL have parameter IDX_W, default 10, meaning predictor index width (bound to CVA6Cfg.GlobalPredictorIndexBits).
REQ-003 SHALL have parameter DEPTH, default 8, meaning in-flight prediction entries; power of two, at least 2.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all in-flight entries.
REQ-007 SHALL have port debug_mode_i  input  1  suppress predictor updates.
REQ-008 SHALL have port push_valid_i  input  1  fetch-side prediction available.
REQ-009 SHALL have port push_ready_o  output  1  entry can be accepted.
REQ-010 SHALL have ports push_pc_i  input  VLEN, push_taken_i  input  1, and push_index_i  input  IDX_W: predicted branch PC, predicted direction and metadata index.
REQ-011 SHALL have port resolve_valid_i  input  1  oldest branch resolved this cycle.
REQ-012 SHALL have ports resolve_pc_i  input  VLEN and resolve_taken_i  input  1: resolved PC and actual outcome.
REQ-013 SHALL have port upd_valid_o  output  1, bht_update_t.valid.
REQ-014 SHALL have ports upd_pc_o  output  VLEN, upd_taken_o  output  1, and upd_index_o  output  IDX_W: the update PC, outcome and metadata.index.
REQ-015 SHALL have port mispredict_o  output  1  resolved outcome differs from the predicted direction.
REQ-016 SHALL have port order_err_o  output  1  sticky error: resolve PC mismatch or resolve with an empty queue.
REQ-017 SHALL have port count_o  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-018 SHALL store accepted pushes in an in-order circular FIFO of DEPTH entries {pc, taken, index}.
REQ-019 SHALL accept a push when push_valid_i && push_ready_o; push_ready_o = (count_o < DEPTH), computed from registered count only.
REQ-020 SHALL NOT accept a push when full, even if a pop occurs in the same cycle.
REQ-021 SHALL pop the head on resolve_valid_i when count_o > 0; read/write pointers SHALL wrap modulo DEPTH.
REQ-022 SHALL, on a pop with resolve_pc_i == head.pc, drive the registered outputs for exactly the next cycle: upd_valid_o = !debug_mode_i, upd_pc_o = head.pc, upd_taken_o = resolve_taken_i, upd_index_o = head.index, mispredict_o = (resolve_taken_i != head.taken).
REQ-023 SHALL, on a pop with a PC mismatch, discard the head, produce no update or mispredict, and set order_err_o from the next cycle.
REQ-024 SHALL ignore resolve_valid_i while empty (a same-cycle push is not matched) and set order_err_o.
REQ-025 SHALL update count_o +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-026 SHALL, on flush_i, clear the pointers and count next cycle, ignore same-cycle push and resolve, and force upd_valid_o and mispredict_o to 0 next cycle.
REQ-027 SHALL deassert upd_valid_o and mispredict_o in every cycle not covered by REQ-022.
REQ-028 SHALL clear order_err_o only on reset; flush_i SHALL NOT clear it.

Reset
REQ-029 SHALL, with rst_ni low at a clock edge, set count_o=0, the pointers to 0, upd_valid_o=0, upd_pc_o=0, upd_taken_o=0, upd_index_o=0, mispredict_o=0 and order_err_o=0.
REQ-030 SHALL treat reset as higher priority than flush, push and resolve; FIFO data contents need not be cleared.

Verification
REQ-031 Push {pc=0x1000, taken=1, idx=5}, then resolve pc=0x1000 taken=0 -> next cycle upd_valid_o=1, upd_taken_o=0, upd_index_o=5, mispredict_o=1; count_o returns to 0.
REQ-032 Push DEPTH entries -> push_ready_o=0, count_o=DEPTH; push and resolve in the same cycle -> push rejected, count_o=DEPTH-1; then fill and drain 2*DEPTH entries -> updates appear in push order across the pointer wrap.
REQ-033 Push pc=0x2000, resolve pc=0x2004 -> no upd_valid_o, order_err_o=1 and stays 1 after flush; only reset clears it.
REQ-034 Three entries queued, flush_i together with a resolve -> next cycle upd_valid_o=0, count_o=0, push_ready_o=1.
REQ-035 debug_mode_i=1 during a matching resolve -> upd_valid_o=0, mispredict_o still valid, entry popped.
REQ-036 Reset asserted mid-stream with 4 entries queued -> all outputs 0 next cycle; first resolve after reset -> order_err_o=1.
